// File: rtl/exe_mem_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// exe_mem_stage_reg_pkg
// Shared constants for the EXE/MEM pipeline boundary.
//   STATUS_N/Z/C/V : bit positions of the flags inside the 4-bit NZCV word
//   STATUS_W       : width of the NZCV word
//   REG_ADDR_W_DEF : default destination register index width
// -----------------------------------------------------------------------------
package exe_mem_stage_reg_pkg;

  localparam int STATUS_W       = 4;
  localparam int STATUS_N       = 3;
  localparam int STATUS_Z       = 2;
  localparam int STATUS_C       = 1;
  localparam int STATUS_V       = 0;
  localparam int REG_ADDR_W_DEF = 4;

endpackage

// File: rtl/exe_mem_stage_reg_status_register.sv
// -----------------------------------------------------------------------------
// status_register
// Architectural NZCV flag register.
// Ports:
//   clk        in   rising-edge clock
//   rstN       in   synchronous active-low reset (clears all flags)
//   weIn       in   write enable; the whole NZCV word is replaced
//   statusIn   in   new {N,Z,C,V}
//   statusOut  out  registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module status_register
  import exe_mem_stage_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rstN,
  input  logic                weIn,
  input  logic [STATUS_W-1:0] statusIn,
  output logic [STATUS_W-1:0] statusOut
);

  logic [STATUS_W-1:0] r_status;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_status <= '0;
    end else if (weIn) begin
      r_status <= statusIn;
    end
  end

  assign statusOut = r_status;

endmodule

// File: rtl/exe_mem_stage_reg.sv
// -----------------------------------------------------------------------------
// exe_mem_stage_reg
// EXE/MEM pipeline register sitting directly after the ALU. Captures the ALU
// result, store data and the EXE control bundle for the memory stage, and owns
// the architectural NZCV register that S-suffixed instructions update.
//
// Ports:
//   clk, rstN                 clock, synchronous active-low reset
//   freezeIn                  memory-stage stall: every register holds
//   flushIn                   turn the instruction in EXE into a bubble
//   validIn                   EXE holds a real, condition-passed instruction
//   sIn                       instruction writes the flags
//   wbEnIn/memREnIn/memWEnIn  control bundle, forwarded when loaded
//   destIn, ALU_ResIn, valRmIn  destination, ALU result, store data
//   statusIn                  ALU flag result {N,Z,C,V}
//   validOut, wbEnOut, memREnOut, memWEnOut, destOut, ALU_ResOut, valRmOut
//                             registered EXE/MEM contents (1-cycle latency)
//   statusRegOut              architectural NZCV
//   carryOut                  stored C flag, feeds the ALU carry input
//
// Optional build macro EXE_STAGE_STATS_EN adds retiredCntOut, freezeCntOut
// and flagUpdCntOut (32-bit wrapping event counters, cleared by reset).
//
// Stall semantics: freezeIn has priority over flushIn. A flush that arrives
// during a freeze must be held by the upstream until the freeze drops; it then
// takes effect on the first unfrozen edge.
// -----------------------------------------------------------------------------
module exe_mem_stage_reg
  import exe_mem_stage_reg_pkg::*;
#(
  parameter int N          = 32,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  freezeIn,
  input  logic                  flushIn,
  input  logic                  validIn,
  input  logic                  sIn,
  input  logic                  wbEnIn,
  input  logic                  memREnIn,
  input  logic                  memWEnIn,
  input  logic [REG_ADDR_W-1:0] destIn,
  input  logic [N-1:0]          ALU_ResIn,
  input  logic [N-1:0]          valRmIn,
  input  logic [STATUS_W-1:0]   statusIn,
  output logic                  validOut,
  output logic                  wbEnOut,
  output logic                  memREnOut,
  output logic                  memWEnOut,
  output logic [REG_ADDR_W-1:0] destOut,
  output logic [N-1:0]          ALU_ResOut,
  output logic [N-1:0]          valRmOut,
  output logic [STATUS_W-1:0]   statusRegOut,
`ifdef EXE_STAGE_STATS_EN
  output logic [31:0]           retiredCntOut,
  output logic [31:0]           freezeCntOut,
  output logic [31:0]           flagUpdCntOut,
`endif
  output logic                  carryOut
);

  logic                  r_valid;
  logic                  r_wb_en;
  logic                  r_mem_r_en;
  logic                  r_mem_w_en;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [N-1:0]          r_alu_res;
  logic [N-1:0]          r_val_rm;

  logic                  w_load;
  logic                  w_status_we;
  logic [STATUS_W-1:0]   w_status;

  // An instruction is accepted only on an unfrozen edge, when not flushed.
  assign w_load      = rstN & ~freezeIn & ~flushIn & validIn;
  assign w_status_we = w_load & sIn;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_dest     <= '0;
      r_alu_res  <= '0;
      r_val_rm   <= '0;
    end else if (!freezeIn) begin
      if (flushIn || !validIn) begin
        // Bubble: payload is zeroed too so MEM never sees stale data.
        r_valid    <= 1'b0;
        r_wb_en    <= 1'b0;
        r_mem_r_en <= 1'b0;
        r_mem_w_en <= 1'b0;
        r_dest     <= '0;
        r_alu_res  <= '0;
        r_val_rm   <= '0;
      end else begin
        r_valid    <= 1'b1;
        r_wb_en    <= wbEnIn;
        r_mem_r_en <= memREnIn;
        r_mem_w_en <= memWEnIn;
        r_dest     <= destIn;
        r_alu_res  <= ALU_ResIn;
        r_val_rm   <= valRmIn;
      end
    end
  end

  status_register u_status_register (
    .clk       (clk),
    .rstN      (rstN),
    .weIn      (w_status_we),
    .statusIn  (statusIn),
    .statusOut (w_status)
  );

  assign validOut     = r_valid;
  assign wbEnOut      = r_wb_en;
  assign memREnOut    = r_mem_r_en;
  assign memWEnOut    = r_mem_w_en;
  assign destOut      = r_dest;
  assign ALU_ResOut   = r_alu_res;
  assign valRmOut     = r_val_rm;
  assign statusRegOut = w_status;
  // Taken from the register, so statusIn never reaches the ALU carry input
  // in the same cycle.
  assign carryOut     = w_status[STATUS_C];

`ifdef EXE_STAGE_STATS_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_freeze_cnt;
  logic [31:0] r_flag_upd_cnt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_retired_cnt  <= '0;
      r_freeze_cnt   <= '0;
      r_flag_upd_cnt <= '0;
    end else begin
      if (w_load)      r_retired_cnt  <= r_retired_cnt + 32'd1;
      if (freezeIn)    r_freeze_cnt   <= r_freeze_cnt + 32'd1;
      if (w_status_we) r_flag_upd_cnt <= r_flag_upd_cnt + 32'd1;
    end
  end

  assign retiredCntOut = r_retired_cnt;
  assign freezeCntOut  = r_freeze_cnt;
  assign flagUpdCntOut = r_flag_upd_cnt;
`endif

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
module tb_exe_mem_stage_reg;

  localparam int N  = 32;
  localparam int AW = 4;
  localparam int VW = 1 + 1 + 1 + 1 + AW + N + N + 4 + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, freezeIn, flushIn, validIn, sIn;
  logic          wbEnIn, memREnIn, memWEnIn;
  logic [AW-1:0] destIn;
  logic [N-1:0]  ALU_ResIn, valRmIn;
  logic [3:0]    statusIn;
  logic          validOut, wbEnOut, memREnOut, memWEnOut, carryOut;
  logic [AW-1:0] destOut;
  logic [N-1:0]  ALU_ResOut, valRmOut;
  logic [3:0]    statusRegOut;
`ifdef EXE_STAGE_STATS_EN
  logic [31:0]   retiredCntOut, freezeCntOut, flagUpdCntOut;
`endif

  exe_mem_stage_reg #(.N(N), .REG_ADDR_W(AW)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .freezeIn     (freezeIn),
    .flushIn      (flushIn),
    .validIn      (validIn),
    .sIn          (sIn),
    .wbEnIn       (wbEnIn),
    .memREnIn     (memREnIn),
    .memWEnIn     (memWEnIn),
    .destIn       (destIn),
    .ALU_ResIn    (ALU_ResIn),
    .valRmIn      (valRmIn),
    .statusIn     (statusIn),
    .validOut     (validOut),
    .wbEnOut      (wbEnOut),
    .memREnOut    (memREnOut),
    .memWEnOut    (memWEnOut),
    .destOut      (destOut),
    .ALU_ResOut   (ALU_ResOut),
    .valRmOut     (valRmOut),
    .statusRegOut (statusRegOut),
`ifdef EXE_STAGE_STATS_EN
    .retiredCntOut(retiredCntOut),
    .freezeCntOut (freezeCntOut),
    .flagUpdCntOut(flagUpdCntOut),
`endif
    .carryOut     (carryOut)
  );

  int checks = 0;
  int errors = 0;

  // Load and store together is an illegal upstream combination.
  always @(posedge clk) begin
    if (rstN === 1'b1)
      assert (!(memREnIn && memWEnIn)) else $error("illegal memREnIn and memWEnIn both high");
  end

  // ---------------------------------------------------------- reference model
  logic          m_valid, m_wb, m_mr, m_mw;
  logic [AW-1:0] m_dest;
  logic [N-1:0]  m_res, m_rm;
  logic [3:0]    m_status;
  logic [31:0]   m_ret, m_frz, m_flg;
  logic [VW-1:0] exp_q[$];

  task automatic model_clear();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_dest = '0; m_res = '0; m_rm = '0; m_status = '0;
    m_ret = '0; m_frz = '0; m_flg = '0;
  endtask

  // What the stage must hold after one edge with the current inputs.
  task automatic model_edge();
    if (!rstN) begin
      model_clear();
    end else if (freezeIn) begin
      m_frz = m_frz + 1;
    end else if (validIn && !flushIn) begin
      if (sIn) begin
        m_status = statusIn;
        m_flg    = m_flg + 1;
      end
      m_ret   = m_ret + 1;
      m_valid = 1; m_wb = wbEnIn; m_mr = memREnIn; m_mw = memWEnIn;
      m_dest  = destIn; m_res = ALU_ResIn; m_rm = valRmIn;
    end else begin
      m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
      m_dest = '0; m_res = '0; m_rm = '0;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_wb, m_mr, m_mw, m_dest, m_res, m_rm, m_status, m_status[1]};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {validOut, wbEnOut, memREnOut, memWEnOut, destOut, ALU_ResOut, valRmOut,
            statusRegOut, carryOut};
  endfunction

  // ------------------------------------------------------------ driver tasks
  task automatic drive(input logic v, input logic s, input logic wb, input logic mr,
                       input logic mw, input logic fz, input logic fl,
                       input logic [AW-1:0] d, input logic [N-1:0] res,
                       input logic [N-1:0] rm, input logic [3:0] st);
    validIn = v; sIn = s; wbEnIn = wb; memREnIn = mr; memWEnIn = mw;
    freezeIn = fz; flushIn = fl; destIn = d; ALU_ResIn = res; valRmIn = rm;
    statusIn = st;
  endtask

  // One clock edge; the model advances on the same edge, outputs sampled #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    exp_q.push_back(exp_vec());
    #1;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    logic [VW-1:0] e;
    rstN = 0;
    drive(1, 1, 1, 1, 1, 1, 1, 4'hF, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 4'hF);
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec() !== '0 || e !== '0) begin
        errors++;
        $display("FAIL reset_edge%0d: got %h expected 0", i, dut_vec());
      end
    end
    rstN = 1;
    drive(1, 0, 1, 1, 0, 0, 0, 4'h9, 32'h1234_5678, 32'h0BAD_F00D, 4'h0);
    step();
    e = exp_q.pop_front();
    checks++;
    if (validOut !== 1'b1 || ALU_ResOut !== 32'h1234_5678 || dut_vec() !== e) begin
      errors++;
      $display("FAIL reset_first_load: got %h expected %h", dut_vec(), e);
    end
  endtask

  task automatic test_pass_through();
    logic [VW-1:0] e;
    drive(1, 1, 1, 0, 0, 0, 0, 4'd5, 32'h8000_0000, $urandom, 4'b1000);
    step();
    e = exp_q.pop_front();
    checks++;
    if (ALU_ResOut !== 32'h8000_0000 || destOut !== 4'd5 || validOut !== 1'b1 ||
        wbEnOut !== 1'b1 || statusRegOut !== 4'b1000 || carryOut !== 1'b0) begin
      errors++;
      $display("FAIL pass_through: got res=%h dest=%0d v=%b st=%b c=%b expected res=80000000 dest=5 v=1 st=1000 c=0",
               ALU_ResOut, destOut, validOut, statusRegOut, carryOut);
    end
    checks++;
    if (dut_vec() !== e) begin
      errors++;
      $display("FAIL pass_through_model: got %h expected %h", dut_vec(), e);
    end
  endtask

  task automatic test_flag_hold();
    logic [N-1:0] r;
    logic [VW-1:0] e;
    r = $urandom;
    drive(1, 0, 1, 0, 0, 0, 0, 4'd3, r, $urandom, 4'b0110);
    step();
    e = exp_q.pop_front();
    checks++;
    if (statusRegOut !== 4'b1000 || ALU_ResOut !== r || dut_vec() !== e) begin
      errors++;
      $display("FAIL flag_hold: got st=%b res=%h expected st=1000 res=%h", statusRegOut, ALU_ResOut, r);
    end
  endtask

  task automatic test_freeze();
    logic [VW-1:0] e, held;
    drive(1, 1, 1, 0, 0, 0, 0, 4'd7, 32'h0000_00AD, 32'h0, 4'b0010);
    step();
    held = exp_q.pop_front();
    checks++;
    if (statusRegOut !== 4'b0010 || carryOut !== 1'b1) begin
      errors++;
      $display("FAIL freeze_load: got st=%b c=%b expected st=0010 c=1", statusRegOut, carryOut);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 1, 0, 4'($urandom), $urandom, $urandom, 4'b0000);
      step();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec() !== held || statusRegOut !== 4'b0010 || e !== held) begin
        errors++;
        $display("FAIL freeze_hold%0d: got %h expected %h", i, dut_vec(), held);
      end
    end
    drive(1, 1, 1, 0, 0, 0, 0, 4'd2, 32'h55, 32'h0, 4'b0000);
    step();
    e = exp_q.pop_front();
    checks++;
    if (statusRegOut !== 4'b0000 || carryOut !== 1'b0 || dut_vec() !== e) begin
      errors++;
      $display("FAIL freeze_release: got st=%b expected st=0000", statusRegOut);
    end
    drive(1, 0, 1, 0, 0, 0, 0, 4'd2, 32'h56, 32'h0, 4'b1111);
    step();
    e = exp_q.pop_front();
    checks++;
    if (statusRegOut !== 4'b0000 || dut_vec() !== e) begin
      errors++;
      $display("FAIL freeze_single_update: got st=%b expected st=0000", statusRegOut);
    end
  endtask

  task automatic test_flush_freeze();
    logic [VW-1:0] e;
    drive(1, 1, 1, 0, 0, 0, 0, 4'd1, 32'h11, 32'h22, 4'b0101);
    step();
    e = exp_q.pop_front();
    drive(1, 1, 0, 0, 1, 0, 1, 4'd4, 32'h33, 32'h44, 4'b1010);
    step();
    e = exp_q.pop_front();
    checks++;
    if (validOut !== 1'b0 || memWEnOut !== 1'b0 || statusRegOut !== 4'b0101 ||
        ALU_ResOut !== '0 || dut_vec() !== e) begin
      errors++;
      $display("FAIL flush_bubble: got v=%b mw=%b st=%b res=%h expected v=0 mw=0 st=0101 res=0",
               validOut, memWEnOut, statusRegOut, ALU_ResOut);
    end
    drive(1, 0, 1, 1, 0, 0, 0, 4'd6, 32'hCAFE_0001, 32'h0, 4'b0000);
    step();
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0, 1, 1, 4'd8, 32'h9999, 32'h0, 4'b1111);
      step();
      e = exp_q.pop_front();
      checks++;
      if (validOut !== 1'b1 || memREnOut !== 1'b1 || ALU_ResOut !== 32'hCAFE_0001 ||
          statusRegOut !== 4'b0101 || dut_vec() !== e) begin
        errors++;
        $display("FAIL freeze_over_flush%0d: got v=%b res=%h expected v=1 res=cafe0001", i, validOut, ALU_ResOut);
      end
    end
    drive(1, 1, 1, 0, 0, 0, 1, 4'd8, 32'h9999, 32'h0, 4'b1111);
    step();
    e = exp_q.pop_front();
    checks++;
    if (validOut !== 1'b0 || ALU_ResOut !== '0 || statusRegOut !== 4'b0101 || dut_vec() !== e) begin
      errors++;
      $display("FAIL flush_after_freeze: got v=%b res=%h st=%b expected v=0 res=0 st=0101",
               validOut, ALU_ResOut, statusRegOut);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [VW-1:0] e;
    drive(1, 1, 1, 0, 0, 1, 0, 4'd3, 32'h77, 32'h88, 4'b1111);
    step();
    e = exp_q.pop_front();
    rstN = 0;
    step();
    e = exp_q.pop_front();
    checks++;
    if (dut_vec() !== '0 || e !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h expected 0", dut_vec());
    end
    rstN = 1;
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    logic mr, mw;
    for (int i = 0; i < 400; i++) begin
      mr = ($urandom_range(0, 3) == 0);
      mw = !mr && ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            mr, mw, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
            4'($urandom), $urandom, $urandom, 4'($urandom));
      step();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec() !== e) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), e);
      end
`ifdef EXE_STAGE_STATS_EN
      checks++;
      if (retiredCntOut !== m_ret || freezeCntOut !== m_frz || flagUpdCntOut !== m_flg) begin
        errors++;
        $display("FAIL random_counters%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                 retiredCntOut, freezeCntOut, flagUpdCntOut, m_ret, m_frz, m_flg);
      end
`endif
    end
  endtask

`ifdef EXE_STAGE_STATS_EN
  task automatic test_counters();
    logic [VW-1:0] e;
    rstN = 0;
    step();
    e = exp_q.pop_front();
    rstN = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, i < 4, 1, 0, 0, 0, 0, 4'($urandom), $urandom, $urandom, 4'($urandom));
      step();
      e = exp_q.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 1, 0, 4'd1, 32'h1, 32'h1, 4'hF);
      step();
      e = exp_q.pop_front();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0, 0, 1, 4'd1, 32'h1, 32'h1, 4'hF);
      step();
      e = exp_q.pop_front();
    end
    checks++;
    if (retiredCntOut !== 32'd10 || freezeCntOut !== 32'd3 || flagUpdCntOut !== 32'd4) begin
      errors++;
      $display("FAIL counters: got %0d/%0d/%0d expected 10/3/4", retiredCntOut, freezeCntOut, flagUpdCntOut);
    end
  endtask
`endif

  // ------------------------------------------------------------------ report
  initial begin
    model_clear();
    rstN = 0;
    drive(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    test_reset();
    test_pass_through();
    test_flag_hold();
    test_freeze();
    test_flush_freeze();
    test_reset_mid_stall();
    test_random();
`ifdef EXE_STAGE_STATS_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- Pipeline boundary directly downstream of the ALU.
- Captures ALU_ResOut, store data and the EXE control bundle into the EXE/MEM register for the memory stage.
- Owns the architectural NZCV status register, updated from the ALU's statusOut for S-suffixed instructions.
- Feeds the stored carry back to the ALU's statusCarryIn and the stored NZCV to ID-stage condition check.

Parameters:
- N, 32, datapath width (ALU result and store data)
- REG_ADDR_W, 4, destination register index width

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rstN  input  1  synchronous active-low reset; sampled on rising clk edge
- freezeIn  input  1  memory-stage stall; all state holds
- flushIn  input  1  kill the instruction currently in EXE; it becomes a bubble
- validIn  input  1  EXE holds a real instruction whose condition passed
- sIn  input  1  instruction sets flags (S bit)
- wbEnIn  input  1  write-back enable
- memREnIn  input  1  load
- memWEnIn  input  1  store
- destIn  input  REG_ADDR_W  destination register
- ALU_ResIn  input  N  ALU result (address for load/store)
- valRmIn  input  N  store data
- statusIn  input  4  ALU statusOut {N,Z,C,V}
- validOut  output  1  MEM-stage instruction valid
- wbEnOut, memREnOut, memWEnOut  output  1 each  registered controls
- destOut  output  REG_ADDR_W  registered destination
- ALU_ResOut  output  N  registered ALU result
- valRmOut  output  N  registered store data
- statusRegOut  output  4  architectural NZCV
- carryOut  output  1  statusRegOut[1]; drives the ALU's statusCarryIn

Behaviour:
- Reset: when rstN=0 at a clk edge, every output register clears to 0, including statusRegOut=4'b0000. Reset overrides freeze and flush, including in the middle of a stall.
- Latency: 1 cycle from inputs to the EXE/MEM outputs. statusRegOut reflects an update on the edge after the flag-setting instruction is in EXE.
- Per edge, in priority order:
  1. reset
  2. freezeIn=1: hold all registers, including status. No double status update, so a frozen ADC/SBC never sees its own carry.
  3. flushIn=1 or validIn=0: load a bubble. validOut, wbEnOut, memREnOut and memWEnOut are 0; destOut, ALU_ResOut and valRmOut are 0. Status holds.
  4. Otherwise: load all inputs and set validOut=1.
- Status write condition: rstN & ~freezeIn & ~flushIn & validIn & sIn.
- Status write data: statusIn is written whole, all 4 bits. Logical ops carry whatever C/V the ALU supplies; no per-flag masking.
- Freeze with flush asserted at the same time: freeze wins. The upstream must hold flushIn until freezeIn drops; the flush then applies on the first unfrozen edge.
- Outputs are pure register outputs. carryOut is a wire from the register, so there is no combinational path from statusIn to carryOut and no loop through the ALU.
- Control inputs wbEnIn/memREnIn/memWEnIn are forwarded unchanged when loaded. memREnIn=memWEnIn=1 together is illegal; the bench flags it as an assertion, and RTL passes it through.

Optional Feature:
- Macro: EXE_STAGE_STATS_EN.
- When defined:
  - Adds outputs retiredCntOut[31:0] (increments on each non-frozen edge loading validOut=1).
  - Adds freezeCntOut[31:0] (increments each edge with freezeIn=1 and rstN=1).
  - Adds flagUpdCntOut[31:0] (increments on each status write).
  - All three clear on reset and wrap modulo 2^32.
- When undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package: status bit indices STATUS_N=3, STATUS_Z=2, STATUS_C=1, STATUS_V=0; STATUS_W=4; REG_ADDR_W default.
- One sub-module: status_register (4-bit, clk/rstN, write enable, holds NZCV).
- The EXE/MEM register and the optional counters live in the top.

Test Plan:
- Reset: drive rstN=0 with all inputs nonzero for 2 edges -> all outputs 0, statusRegOut=0000. Release rstN -> the first valid instruction appears after 1 edge.
- Pass-through: validIn=1, sIn=1, ALU_ResIn=32'h8000_0000, statusIn=1000, destIn=5, wbEnIn=1 -> next edge ALU_ResOut=32'h8000_0000, destOut=5, validOut=1, statusRegOut=1000, carryOut=0.
- Flag hold: sIn=0 with statusIn=0110 -> statusRegOut is unchanged; ALU_ResOut still loads.
- Freeze: load ADC (sIn=1, statusIn=0010), assert freezeIn for 3 edges while statusIn changes to 0000 -> outputs and statusRegOut frozen at prior values. Release -> exactly one update to statusIn.
- Flush and freeze together: flushIn=1 with validIn=1, sIn=1, memWEnIn=1 -> validOut=0, memWEnOut=0, status unchanged. With freezeIn=1 and flushIn=1 together -> hold; dropping freeze with flush still high -> bubble.
- Counters (EXE_STAGE_STATS_EN defined): 10 valid, 3 frozen, 2 flushed, 4 flag-setting edges -> retiredCntOut=10, freezeCntOut=3, flagUpdCntOut=4. Preload 32'hFFFF_FFFF -> wraps to 0.
